// File: rtl/uio_resp_pkg.sv
// Shared state encoding, pin-field indices and bus-direction constants for
// the uio register responder.
package uio_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WACK,
    ST_TURN,
    ST_DRIVE,
    ST_REL
  } state_t;

  localparam int UI_REQ     = 7;
  localparam int UI_RW      = 6;
  localparam int UI_ADDR_HI = 3;
  localparam int UI_ADDR_LO = 0;

  localparam int UO_ACK    = 0;
  localparam int UO_BUSY   = 1;
  localparam int UO_ERR    = 2;
  localparam int UO_CNT_LO = 4;

  localparam logic [3:0] ADDR_ID  = 4'hF;
  localparam logic [7:0] OE_DRIVE = 8'hFF;
  localparam logic [7:0] OE_IN    = 8'h00;

  // Address holes between the last RW register and the ID slot are illegal,
  // and the ID slot itself is read-only.
  function automatic logic addr_err(input logic [3:0] addr, input logic rw,
                                    input int num_regs);
    return ((int'(addr) >= num_regs) && (addr != ADDR_ID)) ||
           (rw && (addr == ADDR_ID));
  endfunction

endpackage

// File: rtl/uio_reg_responder_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level; latency STAGES edges.
// No flow control: the output simply follows the input, delayed.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sh <= '0;
    else        r_sh <= {r_sh[STAGES-2:0], i_d};
  end

  assign o_q = r_sh[STAGES-1];

endmodule

// File: rtl/uio_reg_responder.sv
// Register-file target on the Tiny Tapeout pins with a 4-phase req/ack handshake.
// Write ack 1 edge after synced req, read ack/drive 2 edges after; the initiator paces every phase.
module uio_reg_responder
  import uio_resp_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_REGS    = 15,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       w_req_s;
  logic       w_accept;
  logic       w_rw_in;
  logic [3:0] w_addr_in;
  logic       w_err_in;
  logic       w_wr_en;
  logic [7:0] w_rd_dat;
  logic       w_unused_ui;
  state_t     w_next;

  state_t     r_state;
  logic [3:0] r_addr;
  logic       r_ack;
  logic       r_busy;
  logic       r_err;
  logic [3:0] r_cnt;
  logic [7:0] r_oe;
  logic [7:0] r_rdat;
  logic [7:0] r_regs [NUM_REGS];

  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ui_in[UI_REQ]),
    .o_q   (w_req_s)
  );

  // rw/addr/data are only looked at once req_s is seen, by which point
  // they have been stable for the whole synchronizer delay.
  assign w_rw_in     = ui_in[UI_RW];
  assign w_addr_in   = ui_in[UI_ADDR_HI:UI_ADDR_LO];
  assign w_err_in    = addr_err(w_addr_in, w_rw_in, NUM_REGS);
  assign w_accept    = (r_state == ST_IDLE) && w_req_s && ena;
  assign w_wr_en     = w_accept && w_rw_in && !w_err_in;
  assign w_unused_ui = ^ui_in[5:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_rw_in ? ST_WACK : ST_TURN;
      ST_WACK:  if (!w_req_s) w_next = ST_IDLE;
      ST_TURN:  w_next = ST_DRIVE;
      ST_DRIVE: if (!w_req_s) w_next = ST_REL;
      ST_REL:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_dat = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_addr == 4'(i)) w_rd_dat = r_regs[i];
    end
    if (r_err)                   w_rd_dat = 8'h00;
    else if (r_addr == ADDR_ID)  w_rd_dat = ID_VALUE;
  end

  // Pin outputs are registered off the next state so they change together
  // with the state; TURN always separates IDLE from DRIVE on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
      r_oe   <= OE_IN;
      r_err  <= 1'b0;
      r_cnt  <= '0;
      r_addr <= '0;
      r_rdat <= '0;
    end else begin
      r_ack  <= (w_next == ST_WACK) || (w_next == ST_DRIVE);
      r_busy <= (w_next != ST_IDLE);
      r_oe   <= (w_next == ST_DRIVE) ? OE_DRIVE : OE_IN;
      if (w_accept) begin
        r_addr <= w_addr_in;
        r_err  <= w_err_in;
      end
      if (r_state == ST_TURN) r_rdat <= w_rd_dat;
      if ((r_state != ST_IDLE) && (w_next == ST_IDLE)) r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_addr_in == 4'(i)) r_regs[i] <= uio_in;
      end
    end
  end

  always_comb begin
    uo_out                  = '0;
    uo_out[UO_ACK]          = r_ack;
    uo_out[UO_BUSY]         = r_busy;
    uo_out[UO_ERR]          = r_err;
    uo_out[UO_CNT_LO +: 4]  = r_cnt;
  end

  assign uio_out = r_rdat;
  assign uio_oe  = r_oe;

endmodule

// File: tb/tb_uio_reg_responder.sv
// Bench for uio_reg_responder: vector table, handshake corner sequences and
// randomized transactions against a transaction-level register model.
module tb_uio_reg_responder;

  localparam int NREG = 15;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] m_regs [16];
  logic [3:0] m_cnt;

  typedef struct packed {
    logic       rw;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t tbl [10];

  uio_reg_responder #(
    .SYNC_STAGES (2),
    .NUM_REGS    (NREG),
    .ID_VALUE    (8'hA5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_cnt = 4'd0;
  endtask

  function automatic logic model_err(input logic rw, input logic [3:0] addr);
    return (int'(addr) >= NREG && addr != 4'hF) || (rw && addr == 4'hF);
  endfunction

  function automatic logic [7:0] model_rd(input logic [3:0] addr);
    if (addr == 4'hF)       return 8'hA5;
    if (int'(addr) >= NREG) return 8'h00;
    return m_regs[addr];
  endfunction

  // Full 4-phase transaction from an idle responder, starting at a negedge.
  task automatic do_txn(input logic rw, input logic [3:0] addr, input logic [7:0] wd,
                        input logic drop_ena, output logic [7:0] rd, output logic er);
    int   n;
    logic got;
    logic seen_busy;
    logic exp_err;
    exp_err   = model_err(rw, addr);
    ui_in     = {1'b1, rw, 2'b00, addr};
    uio_in    = wd;
    n         = 0;
    got       = 1'b0;
    seen_busy = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (uo_out[1] && !seen_busy) begin
        seen_busy = 1'b1;
        check("first_busy_oe", 32'(uio_oe), 32'h0);
        if (drop_ena) ena = 1'b0;
      end
      if (uo_out[0]) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'h1);
    check("ack_latency", 32'(n), rw ? 32'd3 : 32'd4);
    check(rw ? "wack_oe" : "drive_oe", 32'(uio_oe), rw ? 32'h00 : 32'hFF);
    rd = uio_out;
    er = uo_out[2];
    check("err", 32'(er), 32'(exp_err));
    if (rw && !exp_err) m_regs[addr] = wd;
    ui_in[7] = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (!uo_out[0]) got = 1'b1;
    end
    check("ack_drop", 32'(got), 32'h1);
    if (!rw) begin
      check("rel_oe", 32'(uio_oe), 32'h0);
      check("rel_busy", 32'(uo_out[1]), 32'h1);
    end
    @(negedge clk);
    m_cnt = m_cnt + 4'd1;
    check("idle_busy", 32'(uo_out[1]), 32'h0);
    check("txn_count", 32'(uo_out[7:4]), 32'(m_cnt));
    ena = 1'b1;
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // The bus must never be driven while the responder reports idle.
  always @(negedge clk) begin
    if (rst_n && !uo_out[1]) check("idle_oe", 32'(uio_oe), 32'h0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       er;
    logic       got;
    int         n;
    logic       t_rw;
    logic [3:0] t_addr;
    logic [7:0] t_wd;
    logic [7:0] t_exp;
    logic       t_drop;

    tbl[0] = '{1'b1, 4'h3, 8'h5A, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 4'h3, 8'h00, 8'h5A, 1'b0};
    tbl[2] = '{1'b0, 4'hF, 8'h00, 8'hA5, 1'b0};
    tbl[3] = '{1'b1, 4'hF, 8'h00, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 4'hF, 8'h00, 8'hA5, 1'b0};
    tbl[5] = '{1'b1, 4'h0, 8'hC7, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 4'hE, 8'h3C, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 4'hE, 8'h00, 8'h3C, 1'b0};
    tbl[8] = '{1'b0, 4'h0, 8'h00, 8'hC7, 1'b0};
    tbl[9] = '{1'b0, 4'h3, 8'h00, 8'h5A, 1'b0};

    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("rst_uo_out", 32'(uo_out), 32'h0);
    check("rst_uio_out", 32'(uio_out), 32'h0);
    check("rst_uio_oe", 32'(uio_oe), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].rw, tbl[i].addr, tbl[i].wd, 1'b0, rd, er);
      check("tbl_err", 32'(er), 32'(tbl[i].exp_err));
      if (!tbl[i].rw) check("tbl_rd", 32'(rd), 32'(tbl[i].exp_rd));
    end

    // ena low: a pending request is ignored until ena rises.
    ena    = 1'b0;
    ui_in  = 8'hC1;
    uio_in = 8'h77;
    got    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (uo_out[0] || uo_out[1]) got = 1'b1;
    end
    check("gate_idle", 32'(got), 32'h0);
    ena = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 2) begin
      @(negedge clk);
      n++;
      if (uo_out[0]) got = 1'b1;
    end
    check("gate_ack", 32'(got), 32'h1);
    m_regs[1] = 8'h77;
    ui_in = 8'h00;
    got   = 1'b0;
    n     = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (!uo_out[0]) got = 1'b1;
    end
    check("gate_drop", 32'(got), 32'h1);
    @(negedge clk);
    m_cnt = m_cnt + 4'd1;
    check("gate_count", 32'(uo_out[7:4]), 32'(m_cnt));

    for (int i = 0; i < 40; i++) begin
      t_rw   = 1'($urandom_range(0, 1));
      t_addr = 4'($urandom_range(0, 15));
      t_wd   = 8'($urandom);
      t_drop = ($urandom_range(0, 3) == 0);
      t_exp  = model_rd(t_addr);
      do_txn(t_rw, t_addr, t_wd, t_drop, rd, er);
      if (!t_rw) check("rand_rd", 32'(rd), 32'(t_exp));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    reset_dut();
    for (int i = 0; i < 17; i++) begin
      t_addr = 4'($urandom_range(0, 14));
      t_wd   = 8'($urandom);
      do_txn(1'b1, t_addr, t_wd, 1'b0, rd, er);
    end
    check("wrap_count", 32'(uo_out[7:4]), 32'h1);

    // Reset asserted while the bus is being driven must release it at once.
    do_txn(1'b1, 4'h3, 8'h99, 1'b0, rd, er);
    ui_in = 8'h83;
    got   = 1'b0;
    n     = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (uio_oe == 8'hFF) got = 1'b1;
    end
    check("drive_reached", 32'(got), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(uio_oe), 32'h0);
    check("rst_mid_uo", 32'(uo_out), 32'h0);
    ui_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_txn(1'b0, 4'h3, 8'h00, 1'b0, rd, er);
    check("post_rst_rd", 32'(rd), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uio_reg_responder.md
Name: uio_reg_responder

Overview:
- Target-side responder for the Tiny Tapeout pin interface. The harness, acting as initiator, issues register read/write transactions on ui_in with a 4-phase req/ack handshake.
- The block hosts a small register file and manages bidirectional uio bus turnaround through uio_oe.
- It sits as the core of a tt_um_* top-level and exposes status on uo_out.

Parameters:
- SYNC_STAGES, 2, flops in the req synchronizer (legal: 2 or 3).
- NUM_REGS, 15, read/write registers at addresses 0..NUM_REGS-1 (legal: 1..15).
- ID_VALUE, 8'hA5, read-only constant returned at address 15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design selected; new transactions are accepted only when high.
- ui_in  in  8  [7] req, [6] rw (1=write, 0=read), [5:4] unused, [3:0] addr.
- uio_in  in  8  write data; must be stable while req is high.
- uo_out  out  8  [0] ack, [1] busy, [2] err, [3] 0, [7:4] txn_count.
- uio_out  out  8  read data.
- uio_oe  out  8  8'hFF while driving read data, else 8'h00.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; uo_out=0; uio_out=0; uio_oe=0.
  - All registers = 8'h00; txn_count=0; err=0.
- Synchronizer: ui_in[7] passes through SYNC_STAGES flops to give req_s. rw, addr and uio_in are sampled unsynchronized, only when req_s is first seen high (they have been stable for >= SYNC_STAGES cycles by then).
- FSM states: IDLE, WACK, TURN, DRIVE, REL.
- IDLE:
  - Entry condition: req_s=1 and ena=1. Latch addr and rw.
  - Compute err = (addr >= NUM_REGS and addr != 15) or (rw=1 and addr=15).
  - Write: if no err, reg[addr] <= uio_in. Next state WACK.
  - Read: next state TURN.
  - If req_s=1 with ena=0: stay in IDLE, nothing captured.
- WACK: ack=1, busy=1. Leave to IDLE when req_s=0; on that transition ack goes to 0 and txn_count increments.
- TURN: ack=0, uio_oe=0 (bus turnaround cycle).
  - uio_out <= reg[addr] for a valid RW address, ID_VALUE for address 15, 8'h00 on err.
  - Next state DRIVE.
- DRIVE: uio_oe=8'hFF, ack=1, busy=1. Leave to REL when req_s=0.
- REL: uio_oe=0, ack=0, busy=1. txn_count increments. Next state IDLE.
- Output timing: all outputs are registered. busy=1 in every state except IDLE. uio_oe is never high in the cycle immediately after IDLE.
- Latency, with req rising before edge 0:
  - req_s high after SYNC_STAGES edges.
  - Write ack high 1 edge later.
  - Read ack and uio_oe high 2 edges later.
- err: updated on every accepted transaction and held until the next one. An erroring write completes the handshake normally.
- txn_count: 4-bit, wraps 15 -> 0. Errored transactions count.
- ena dropping mid-transaction: no effect; the transaction completes.
- req glitch: a req_s pulse shorter than one clock is not detected. A req high for exactly one synchronized cycle still completes WACK or DRIVE, then returns to IDLE.
- Reset mid-DRIVE: uio_oe clears immediately (asynchronously).

Decomposition:
- Package uio_resp_pkg holds:
  - state enum type (IDLE, WACK, TURN, DRIVE, REL);
  - bit-index constants for the ui_in and uo_out fields;
  - ADDR_ID = 4'hF;
  - OE_DRIVE = 8'hFF, OE_IN = 8'h00.
- One sub-module, sync_bit: an SYNC_STAGES-deep synchronizer with async active-low reset to 0.

Test Plan:
- Write then read:
  - ui_in=8'hC3 (write, addr 3), uio_in=8'h5A; ack=1 by edge 3. Drop req; ack=0, txn_count=1.
  - ui_in=8'h83 (read, addr 3); by edge 4 uio_oe=8'hFF, uio_out=8'h5A, ack=1, err=0.
- ID read: ui_in=8'h8F -> uio_out=8'hA5, err=0. Write ui_in=8'hCF with uio_in=8'h00 -> err=1; a following read of addr 15 still returns 8'hA5.
- ena gating: ena=0 with ui_in=8'hC1 held 10 cycles -> ack stays 0, busy stays 0. Raise ena -> ack=1 within 2 edges.
- Turnaround: on every read, check the cycle after IDLE has uio_oe=0 (TURN). After req falls, check uio_oe=0 and ack=0 in the same cycle (REL). Verify uio_oe is never 8'hFF while state is IDLE.
- Wrap: 17 back-to-back writes -> txn_count reads 1.
- Reset mid-read: assert rst_n=0 during DRIVE -> uio_oe=0 and uo_out=0 without waiting for a clock edge. Register 3 reads 8'h00 after release.
